cpu_bus_arbiter: RTL

Sequences the CPU core's single external bus master port and shares it between the instruction-fetch stage (IF) and the memory-access stage (MEM). It runs one bus transaction at a time through a request/grant/strobe/ready handshake, with MEM having fixed priority over IF. It drives per-stage `busy` stall signals into the pipeline controller, and captures read data for the winning stage. It also ignores misaligned MEM accesses, abandons an IF fetch on flush before it is granted, and times out hung slaves.

---
 rtl/cpu_bus_arbiter_pkg.sv | 20 ++
 rtl/cpu_bus_arbiter_timeout.sv | 29 ++
 rtl/cpu_bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and defaults for the CPU external bus arbiter.
// State encodings are fixed so they match the legacy numbering.
package cpu_bus_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cpu_bus_arbiter_timeout.sv
// Wait-state counter for a bus transaction.
// Asserts expired once TIMEOUT-1 cycles have been counted since the last clear.
module bus_timeout_cnt
   import cpu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the core's single external bus master port between IF and MEM,
// MEM having fixed priority; one transaction at a time with hung-slave timeout.
module cpu_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = 30,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rd_data,
   output logic              if_busy,
   input  logic              flush,
   input  logic              mem_req,
   input  logic              mem_rw,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   input  logic              miss_align,
   output logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_busy,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic              bus_as,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy,
   output logic              bus_err
);

   state_t            state;
   state_t            state_nxt;
   owner_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [DATA_W-1:0] wdata_q;

   logic mem_elig;
   logic if_elig;
   logic cnt_clear;
   logic cnt_en;
   logic expired;
   logic drive_bus;

   assign mem_elig = mem_req & ~miss_align;
   assign if_elig  = if_req  & ~flush;

   // Clearing while in ACCESS means the count starts at zero on WAIT entry.
   assign cnt_clear = (state == ACCESS);
   assign cnt_en    = (state == WAIT);

   bus_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_elig || if_elig) state_nxt = REQ;
         REQ: begin
            if (bus_grant)
               state_nxt = ACCESS;
            else if (owner == OWN_IF && flush)
               state_nxt = IDLE;
         end
         ACCESS:  state_nxt = WAIT;
         WAIT:    if (bus_rdy || expired) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWN_MEM;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         wdata_q     <= '0;
         if_rd_data  <= '0;
         mem_rd_data <= '0;
         bus_err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         bus_err <= 1'b0;

         if (state == IDLE) begin
            if (mem_elig) begin
               owner   <= OWN_MEM;
               addr_q  <= mem_addr;
               rw_q    <= mem_rw;
               wdata_q <= mem_wr_data;
            end else if (if_elig) begin
               owner   <= OWN_IF;
               addr_q  <= if_addr;
               rw_q    <= 1'b0;
               wdata_q <= '0;
            end
         end

         // A ready on the final counted cycle still completes normally.
         if (state == WAIT) begin
            if (bus_rdy) begin
               if (!rw_q) begin
                  if (owner == OWN_IF)
                     if_rd_data <= bus_rd_data;
                  else
                     mem_rd_data <= bus_rd_data;
               end
            end else if (expired) begin
               bus_err <= 1'b1;
               if (owner == OWN_IF)
                  if_rd_data <= '0;
               else
                  mem_rd_data <= '0;
            end
         end
      end
   end

   assign drive_bus   = (state == ACCESS) || (state == WAIT);
   assign bus_req     = (state == REQ) || drive_bus;
   assign bus_as      = (state == ACCESS);
   assign bus_rw      = drive_bus ? rw_q    : 1'b0;
   assign bus_addr    = drive_bus ? addr_q  : '0;
   assign bus_wr_data = drive_bus ? wdata_q : '0;

   assign if_busy  = if_elig  & ~(state == DONE && owner == OWN_IF);
   assign mem_busy = mem_elig & ~(state == DONE && owner == OWN_MEM);

endmodule
